// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master side is the operand source and result consumer; the slave side is the adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Produces one WIDTH-bit result every WIDTH+2 cycles through valid/ready handshakes.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             s_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_nxt;

  // The single full-adder cell and the result shift-in.
  always_comb begin
    s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    res_nxt          = res_q >> 1;
    res_nxt[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            // Subtraction is a + ~b + 1.
            b_q        <= bus.sub ? ~bus.b : bus.b;
            carry_q    <= bus.sub | bus.cin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_nxt;
          carry_q <= carry_nxt;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // carry_q here is the carry into the MSB.
            sum_q       <= res_nxt;
            cout_q      <= carry_nxt;
            ovf_q       <= carry_q ^ carry_nxt;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 arithmetic, handshake and reset cases,
// plus a WIDTH=1 instance checked against the full-adder truth table.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  serial_adder_if #(.WIDTH(8)) i8 ();
  serial_adder_if #(.WIDTH(1)) i1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (i8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (i1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic accept8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic sb);
    int n;
    i8.a        = av;
    i8.b        = bv;
    i8.cin      = ci;
    i8.sub      = sb;
    i8.in_valid = 1'b1;
    n = 0;
    while (!i8.in_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " ready"}, 32'(i8.in_ready), 32'd1);
    @(posedge clk);
    #1;
    i8.in_valid = 1'b0;
  endtask

  task automatic wait_done8(input string tag, input logic [7:0] es, input logic ec,
                            input logic eo);
    int lat;
    lat = 0;
    while (!i8.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " lat"}, 32'(lat), 32'd8);
    check({tag, " sum"}, 32'(i8.sum), 32'(es));
    check({tag, " cout"}, 32'(i8.cout), 32'(ec));
    check({tag, " ovf"}, 32'(i8.overflow), 32'(eo));
  endtask

  task automatic release8(input string tag);
    i8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    i8.out_ready = 1'b0;
    check({tag, " idle vld"}, 32'(i8.out_valid), 32'd0);
    check({tag, " idle rdy"}, 32'(i8.in_ready), 32'd1);
  endtask

  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic ci, input logic sb, input logic [7:0] es, input logic ec,
                     input logic eo);
    accept8(tag, av, bv, ci, sb);
    wait_done8(tag, es, ec, eo);
    release8(tag);
  endtask

  task automatic op1(input string tag, input logic av, input logic bv, input logic ci,
                     input logic ec, input logic es, input logic eo);
    int n;
    i1.a        = av;
    i1.b        = bv;
    i1.cin      = ci;
    i1.sub      = 1'b0;
    i1.in_valid = 1'b1;
    n = 0;
    while (!i1.in_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    i1.in_valid = 1'b0;
    n = 0;
    while (!i1.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " lat"}, 32'(n), 32'd1);
    check({tag, " cs"}, {30'd0, i1.cout, i1.sum}, {30'd0, ec, es});
    check({tag, " ovf"}, 32'(i1.overflow), 32'(eo));
    i1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    i1.out_ready = 1'b0;
  endtask

  // {a, b, cin, cout, sum, ovf}
  logic [5:0] fa_tab [8] = '{
    6'b000_000, 6'b001_011, 6'b010_010, 6'b011_100,
    6'b100_010, 6'b101_100, 6'b110_101, 6'b111_110
  };

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0; i8.sub = 1'b0;
    i8.out_ready = 1'b0;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0; i1.sub = 1'b0;
    i1.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst vld", 32'(i8.out_valid), 32'd0);
    check("rst rdy", 32'(i8.in_ready), 32'd1);
    check("rst sum", 32'(i8.sum), 32'd0);
    check("rst cout", 32'(i8.cout), 32'd0);
    check("rst ovf", 32'(i8.overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op8("add0f01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add7f00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("sub0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op8("sub0707", 8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

    // Result held in DONE while new operands wait on in_valid.
    accept8("hold", 8'h3C, 8'hA5, 1'b1, 1'b0);
    wait_done8("hold", 8'hE2, 1'b0, 1'b0);
    i8.a = 8'h11; i8.b = 8'h22; i8.cin = 1'b0; i8.sub = 1'b0; i8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold sum", 32'(i8.sum), 32'h0E2);
      check("hold rdy", 32'(i8.in_ready), 32'd0);
      check("hold vld", 32'(i8.out_valid), 32'd1);
    end
    i8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    i8.out_ready = 1'b0;
    check("rel rdy", 32'(i8.in_ready), 32'd1);
    check("rel vld", 32'(i8.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rel acc", 32'(i8.in_ready), 32'd0);
    i8.in_valid = 1'b0;
    wait_done8("rel", 8'h33, 1'b0, 1'b0);
    release8("rel");

    // Reset while bit 4 is in flight.
    accept8("rstrun", 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstrun vld", 32'(i8.out_valid), 32'd0);
    check("rstrun rdy", 32'(i8.in_ready), 32'd1);
    check("rstrun sum", 32'(i8.sum), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("rstrun quiet", 32'(i8.out_valid), 32'd0);
    op8("after", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [5:0] r;
      r = fa_tab[i];
      op1($sformatf("w1_%0d", i), r[5], r[4], r[3], r[2], r[1], r[0]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
